// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among NREQ requesters.
// The winner's request is latched and held on the memory port until mem_data_ok; the response goes back to the winner.
module mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 64,
  parameter int DW   = 64,
  localparam int SW  = DW / 8,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*3-1:0]    req_size,
  input  logic [NREQ*SW-1:0]   req_strobe,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      resp_data_ok,
  output logic [DW-1:0]        resp_data,
  output logic                 mem_valid,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_write,
  output logic [2:0]           mem_size,
  output logic [SW-1:0]        mem_strobe,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_data_ok,
  input  logic [DW-1:0]        mem_rdata,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   ptr_after;
  logic            any_valid;

  logic [AW-1:0]   addr_a   [NREQ];
  logic [2:0]      size_a   [NREQ];
  logic [SW-1:0]   strobe_a [NREQ];
  logic [DW-1:0]   wdata_a  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]   = req_addr[i*AW +: AW];
    assign size_a[i]   = req_size[i*3 +: 3];
    assign strobe_a[i] = req_strobe[i*SW +: SW];
    assign wdata_a[i]  = req_wdata[i*DW +: DW];
  end

  // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so no index >= NREQ is ever formed.
  always_comb begin : pick_winner
    int            idx;
    logic [IW-1:0] cand;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    win       = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!any_valid && req_valid[cand]) begin
        win       = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign ptr_after = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; the reset is synchronous, sampled on the edge.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (any_valid)   state_next = REQ;
      REQ:  if (mem_data_ok) state_next = IDLE;
    endcase
  end

  // Latched request fields, owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_size   <= '0;
      mem_strobe <= '0;
      mem_wdata  <= '0;
    end else if (state == IDLE && any_valid) begin
      grant_id   <= win;
      mem_addr   <= addr_a[win];
      mem_write  <= req_write[win];
      mem_size   <= size_a[win];
      mem_strobe <= strobe_a[win];
      mem_wdata  <= wdata_a[win];
    end else if (state == REQ && mem_data_ok) begin
      rr_ptr <= ptr_after;
    end
  end

  // Outputs. The completion pulse is masked during reset so an abandoned transaction is never acknowledged.
  always_comb begin
    mem_valid    = (state == REQ);
    busy         = (state == REQ);
    resp_data    = mem_rdata;
    resp_data_ok = '0;
    if (state == REQ && mem_data_ok && reset)
      resp_data_ok[grant_id] = req_valid[grant_id];
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is compared every cycle,
// plus literal expectations for each scenario.
module tb_mem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*3-1:0]   req_size;
  logic [NREQ*SW-1:0]  req_strobe;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     resp_data_ok;
  logic [DW-1:0]       resp_data;
  logic                mem_valid;
  logic [AW-1:0]       mem_addr;
  logic                mem_write;
  logic [2:0]          mem_size;
  logic [SW-1:0]       mem_strobe;
  logic [DW-1:0]       mem_wdata;
  logic                mem_data_ok;
  logic [DW-1:0]       mem_rdata = '0;
  logic                grant_id;
  logic                busy;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_strobe   (req_strobe),
    .req_wdata    (req_wdata),
    .resp_data_ok (resp_data_ok),
    .resp_data    (resp_data),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_strobe   (mem_strobe),
    .mem_wdata    (mem_wdata),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Memory side: fixed-latency responder, zero-wait tie, or manual pulses.
  int          mem_lat    = -1;
  int          lat_cnt    = 0;
  logic        mem_ok_r   = 1'b0;
  logic        mem_ok_man = 1'b0;
  logic        zero_wait  = 1'b0;
  logic [31:0] seq        = '0;

  assign mem_data_ok = zero_wait ? mem_valid : ((mem_lat >= 0) ? mem_ok_r : mem_ok_man);

  always begin
    @(posedge clk);
    #1;
    if (mem_lat < 0 || mem_valid !== 1'b1) begin
      mem_ok_r = 1'b0;
      lat_cnt  = 0;
    end else if (lat_cnt == mem_lat) begin
      mem_ok_r  = 1'b1;
      seq       = seq + 1;
      mem_rdata = {32'hDEAD_BEEF, seq};
      lat_cnt   = 0;
    end else begin
      mem_ok_r = 1'b0;
      lat_cnt++;
    end
  end

  // Transaction-level model: one outstanding job, owner, next round-robin start.
  logic            started = 1'b0;
  logic            m_busy  = 1'b0;
  int              m_owner = 0;
  int              m_ptr   = 0;
  logic [AW-1:0]   m_addr  = '0;
  logic            m_write = 1'b0;
  logic [2:0]      m_size  = '0;
  logic [SW-1:0]   m_strobe = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic [NREQ-1:0] exp_ok;
  logic            found;
  int              c_idx;
  logic            prev_mv = 1'b0;

  int              grant_log[$];
  int              resp_id_log[$];
  logic [DW-1:0]   resp_dat_log[$];

  always @(negedge clk) begin
    exp_ok = '0;
    if (m_busy && mem_data_ok === 1'b1 && reset === 1'b1)
      exp_ok[m_owner] = req_valid[m_owner];
    if (started) begin
      check("mem_valid", {63'd0, mem_valid}, {63'd0, m_busy});
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("grant_id", {63'd0, grant_id}, 64'(m_owner));
      check("mem_addr", mem_addr, m_addr);
      check("mem_write", {63'd0, mem_write}, {63'd0, m_write});
      check("mem_size", {61'd0, mem_size}, {61'd0, m_size});
      check("mem_strobe", {56'd0, mem_strobe}, {56'd0, m_strobe});
      check("mem_wdata", mem_wdata, m_wdata);
      check("resp_data_ok", {62'd0, resp_data_ok}, {62'd0, exp_ok});
      if (exp_ok != '0) check("resp_data", resp_data, mem_rdata);
    end
    if (mem_valid === 1'b1 && prev_mv !== 1'b1) grant_log.push_back(int'(grant_id));
    prev_mv = mem_valid;
    if (resp_data_ok !== '0) begin
      resp_id_log.push_back(int'(resp_data_ok));
      resp_dat_log.push_back(resp_data);
    end
    // Advance the model to the state after the coming edge.
    if (reset !== 1'b1) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0;
      m_addr = '0; m_write = 1'b0; m_size = '0; m_strobe = '0; m_wdata = '0;
      started = 1'b1;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        c_idx = (m_ptr + k) % NREQ;
        if (!found && req_valid[c_idx]) begin
          found    = 1'b1;
          m_busy   = 1'b1;
          m_owner  = c_idx;
          m_addr   = req_addr[c_idx*AW +: AW];
          m_write  = req_write[c_idx];
          m_size   = req_size[c_idx*3 +: 3];
          m_strobe = req_strobe[c_idx*SW +: SW];
          m_wdata  = req_wdata[c_idx*DW +: DW];
        end
      end
    end else if (mem_data_ok === 1'b1) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic w,
                         input logic [2:0] sz, input logic [SW-1:0] st, input logic [DW-1:0] wd);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_size[i*3 +: 3]    = sz;
    req_strobe[i*SW +: SW] = st;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    resp_id_log.delete();
    resp_dat_log.delete();
  endtask

  int waits;

  initial begin
    reset = 1'b0;
    req_valid = '0; req_addr = '0; req_write = '0; req_size = '0; req_strobe = '0; req_wdata = '0;
    mem_lat = 2;
    set_req(0, 1'b1, 64'h8000_0000, 1'b0, 3'd3, 8'hFF, 64'd0);
    set_req(1, 1'b1, 64'h8000_0100, 1'b0, 3'd3, 8'hFF, 64'd0);

    // 1: reset held with both requesting, then first grant goes to requester 0.
    step(3);
    check("t1_rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("t1_rst_resp_ok", {62'd0, resp_data_ok}, 64'd0);
    check("t1_rst_grant", {63'd0, grant_id}, 64'd0);
    clear_logs();
    reset = 1'b1;
    step(1);
    check("t1_grant", {63'd0, grant_id}, 64'd0);
    check("t1_addr", mem_addr, 64'h8000_0000);
    check("t1_busy", {63'd0, busy}, 64'd1);

    // 2: both continuously valid, 2-cycle memory: grants alternate.
    waits = 0;
    while (resp_id_log.size() < 4 && waits < 60) begin
      step(1);
      waits++;
    end
    req_valid = '0;
    mem_lat   = -1;
    check("t2_resp_count", 64'(resp_id_log.size()), 64'd4);
    check("t2_grant_count", 64'(grant_log.size()), 64'd4);
    check("t2_grant0", 64'(grant_log[0]), 64'd0);
    check("t2_grant1", 64'(grant_log[1]), 64'd1);
    check("t2_grant2", 64'(grant_log[2]), 64'd0);
    check("t2_grant3", 64'(grant_log[3]), 64'd1);
    check("t2_resp0", 64'(resp_id_log[0]), 64'd1);
    check("t2_resp1", 64'(resp_id_log[1]), 64'd2);
    check("t2_data0", resp_dat_log[0], 64'hDEAD_BEEF_0000_0001);
    check("t2_data3", resp_dat_log[3], 64'hDEAD_BEEF_0000_0004);

    // 3: single store from requester 1; input changes during the transaction are ignored.
    clear_logs();
    set_req(1, 1'b1, 64'h8000_1008, 1'b1, 3'd2, 8'hF0, 64'h1122_3344_5566_7788);
    step(1);
    check("t3_grant", {63'd0, grant_id}, 64'd1);
    check("t3_write", {63'd0, mem_write}, 64'd1);
    check("t3_addr", mem_addr, 64'h8000_1008);
    check("t3_strobe", {56'd0, mem_strobe}, 64'hF0);
    check("t3_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    set_req(1, 1'b1, 64'h0000_0040, 1'b0, 3'd0, 8'h01, 64'hFFFF_0000_FFFF_0000);
    step(2);
    check("t3_hold_addr", mem_addr, 64'h8000_1008);
    check("t3_hold_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    check("t3_hold_write", {63'd0, mem_write}, 64'd1);
    mem_ok_man = 1'b1;
    #1;
    check("t3_resp_ok", {62'd0, resp_data_ok}, 64'b10);
    step(1);
    mem_ok_man   = 1'b0;
    req_valid[1] = 1'b0;
    check("t3_idle", {63'd0, busy}, 64'd0);

    // 4: owner drops valid mid-transaction; completion is silently discarded.
    clear_logs();
    set_req(0, 1'b1, 64'h8000_2000, 1'b0, 3'd3, 8'hFF, 64'd0);
    step(1);
    check("t4_grant", {63'd0, grant_id}, 64'd0);
    step(1);
    req_valid[0] = 1'b0;
    step(3);
    mem_ok_man = 1'b1;
    #1;
    check("t4_no_resp", {62'd0, resp_data_ok}, 64'd0);
    step(1);
    mem_ok_man = 1'b0;
    check("t4_idle", {63'd0, busy}, 64'd0);
    check("t4_resp_log", 64'(resp_id_log.size()), 64'd0);
    req_valid = 2'b11;
    step(1);
    check("t4_ptr_adv", {63'd0, grant_id}, 64'd1);
    mem_ok_man = 1'b1;
    step(1);
    mem_ok_man = 1'b0;
    req_valid  = '0;

    // 5: zero-wait memory, one grant every two cycles; a late requester 1 wins next.
    clear_logs();
    zero_wait = 1'b1;
    set_req(0, 1'b1, 64'h8000_3000, 1'b0, 3'd3, 8'hFF, 64'd0);
    step(8);
    check("t5_grants", 64'(grant_log.size()), 64'd4);
    check("t5_resps", 64'(resp_id_log.size()), 64'd4);
    grant_log.delete();
    set_req(1, 1'b1, 64'h8000_4000, 1'b0, 3'd3, 8'hFF, 64'd0);
    step(2);
    req_valid[1] = 1'b0;
    step(2);
    check("t5_inj_count", 64'(grant_log.size()), 64'd2);
    check("t5_inj_first", 64'(grant_log[0]), 64'd1);
    check("t5_inj_second", 64'(grant_log[1]), 64'd0);
    req_valid = '0;
    zero_wait = 1'b0;

    // 6: reset during the completion cycle abandons the transaction and clears the pointer.
    req_valid = 2'b11;
    step(1);
    check("t6_grant", {63'd0, grant_id}, 64'd1);
    step(1);
    reset      = 1'b0;
    mem_ok_man = 1'b1;
    #1;
    check("t6_no_resp", {62'd0, resp_data_ok}, 64'd0);
    step(1);
    reset      = 1'b1;
    mem_ok_man = 1'b0;
    check("t6_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_addr_clr", mem_addr, 64'd0);
    step(1);
    check("t6_ptr_zero", {63'd0, grant_id}, 64'd0);
    check("t6_busy_again", {63'd0, busy}, 64'd1);
    mem_ok_man = 1'b1;
    step(1);
    mem_ok_man = 1'b0;
    req_valid  = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
